il_share_arbiter: RTL

- Shares one interleaver instance between two independent frame sources.
- Arbitrates requests round-robin and issues one-cycle enable/data strokes to the interleaver.
- Tracks in-flight frames with an in-order tag queue and routes each interleaved result back to the source that issued it.
- Sits between the framing logic and the interleaver; it also flags protocol errors.

---
 rtl/il_share_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/il_share_arbiter.sv
// Two-source round-robin front end for a single shared interleaver.
// Frames are issued as one-cycle strokes; an in-order tag queue routes
// each interleaver result back to the source that issued the frame.
module il_share_arbiter #(
    parameter int unsigned W       = 28,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned GAP     = 0,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic [W-1:0] s0_data,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic [W-1:0] s1_data,
    output logic         il_en,
    output logic [W-1:0] il_data,
    input  logic         il_done,
    input  logic [W-1:0] il_result,
    output logic         m0_valid,
    output logic [W-1:0] m0_data,
    output logic         m1_valid,
    output logic [W-1:0] m1_data,
    output logic         busy,
    output logic         err_timeout,
    output logic         err_spurious
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned AW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            rr_last_q;      // 1: source 1 won the last transfer
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH-1:0] tag_q;
    logic [AW-1:0]   age_q;

    logic grant_ok, xfer0, xfer1, push, pop, head_tag;

    // Grant only from IDLE with a free slot; a pop this cycle does not count
    assign grant_ok = (state_q == ST_IDLE) && (count_q < CW'(DEPTH));
    assign s0_ready = grant_ok & s0_valid & (~s1_valid | rr_last_q);
    assign s1_ready = grant_ok & s1_valid & (~s0_valid | ~rr_last_q);

    assign xfer0    = s0_valid & s0_ready;
    assign xfer1    = s1_valid & s1_ready;
    assign push     = xfer0 | xfer1;
    assign pop      = il_done & (count_q != '0);
    assign head_tag = tag_q[rd_ptr_q];
    assign count_d  = count_q + CW'(push) - CW'(pop);

    // Issue FSM next state: optional idle gap after every issue
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (push && (GAP > 0)) begin
                    state_d = ST_GAP;
                    gap_d   = GW'(GAP - 1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Tag queue, round-robin pointer and oldest-frame age
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= 1'b1;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_q     <= '0;
            age_q     <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                tag_q[wr_ptr_q] <= xfer1;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
                rr_last_q       <= xfer1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (pop || (push && (count_q == '0))) begin
                age_q <= '0;
            end else if ((count_q != '0) && (age_q != AW'(TIMEOUT))) begin
                age_q <= age_q + AW'(1);
            end
        end
    end

    // Registered interleaver strokes, result routing, status and error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            il_en        <= 1'b0;
            il_data      <= '0;
            m0_valid     <= 1'b0;
            m0_data      <= '0;
            m1_valid     <= 1'b0;
            m1_data      <= '0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            il_en    <= push;
            if (push) begin
                il_data <= xfer1 ? s1_data : s0_data;
            end
            m0_valid <= pop & ~head_tag;
            m1_valid <= pop & head_tag;
            if (pop && !head_tag) begin
                m0_data <= il_result;
            end
            if (pop && head_tag) begin
                m1_data <= il_result;
            end
            busy         <= (count_d != '0) | (state_d == ST_GAP);
            err_timeout  <= err_timeout | (age_q == AW'(TIMEOUT));
            err_spurious <= err_spurious | (il_done & (count_q == '0));
        end
    end

endmodule
